// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU MEM stage and a DMA/debug loader.
// Optional build macro DM_ARB_PROT_EN adds a write-protected byte window for DMA writes.
module dm_arbiter #(
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] PROT_LO  = 32'h0000_0000,
    parameter logic [31:0] PROT_HI  = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        rstn,
    // Handshake (both requesters): req is held with wr/addr/wdata stable until
    // ack; ack is a one-cycle pulse during which the access happens. A req still
    // high at the posedge that closes the ack cycle is taken as a new request.
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } state_t;

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          force_dma;
    logic          lat_wr;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          prot_hit;

    assign force_dma = (wait_cnt == WAIT_MAX);

    // Same grant rule in every state, so an owner can be re-granted back to back.
    always_comb begin
        state_nxt = IDLE;
        if (force_dma && dma_req) begin
            state_nxt = DMA_ACC;
        end else if (cpu_req) begin
            state_nxt = CPU_ACC;
        end else if (dma_req) begin
            state_nxt = DMA_ACC;
        end
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (!dma_req || state_nxt == DMA_ACC) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            case (state_nxt)
                CPU_ACC: begin
                    lat_wr    <= cpu_wr;
                    lat_addr  <= cpu_addr;
                    lat_wdata <= cpu_wdata;
                end
                DMA_ACC: begin
                    lat_wr    <= dma_wr;
                    lat_addr  <= dma_addr;
                    lat_wdata <= dma_wdata;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DM_ARB_PROT_EN
    assign prot_hit = (state == DMA_ACC) && lat_wr &&
                      (lat_addr >= PROT_LO) && (lat_addr <= PROT_HI);
`else
    // Window parameters stay referenced so both builds share one parameter list.
    assign prot_hit = 1'b0 & (PROT_LO <= PROT_HI);
`endif

    always_comb begin
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        dma_ack   = 1'b0;
        dma_rdata = '0;
        dma_err   = 1'b0;
        case (state)
            CPU_ACC: begin
                dm_we     = lat_wr;
                dm_addr   = lat_addr;
                dm_wdata  = lat_wdata;
                cpu_ack   = 1'b1;
                cpu_rdata = dm_rdata;
            end
            DMA_ACC: begin
                dm_we     = lat_wr & ~prot_hit;
                dm_addr   = lat_addr;
                dm_wdata  = lat_wdata;
                dma_ack   = 1'b1;
                dma_rdata = dm_rdata;
                dma_err   = prot_hit;
            end
            default: begin
            end
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign dbg_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: scenario tasks plus randomized traffic against a grant/memory reference model.
module tb_dm_arbiter;

    localparam int MAX_WAIT = 4;
`ifdef DM_ARB_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack, dma_err;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [1:0]  dbg_state;

    dm_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dbg_state(dbg_state)
    );

    // clock / memory environment
    always #5 clk = ~clk;

    logic [31:0] mem [256] = '{default: 32'h0};
    assign dm_rdata = mem[dm_addr[9:2]];
    always @(negedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;

    // reference model and scoreboard
    typedef struct packed {
        logic        cpu_ack;
        logic        dma_ack;
        logic        dma_err;
        logic        dm_we;
        logic        cpu_stall;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] cpu_rdata;
        logic [31:0] dma_rdata;
    } obs_t;

    int          total = 0;
    int          bad = 0;
    int          m_owner;   // 0 none, 1 cpu, 2 dma
    int          m_wait;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];

    function automatic bit blocked();
        return PROT && m_owner == 2 && m_wr && (m_addr <= 32'hFF);
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_wait  = 0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        exp_q.delete();
    endtask

    // Advance the model across one posedge using the inputs currently driven.
    task automatic model_clock();
        int g;
        if (m_owner != 0 && m_wr && !blocked()) ref_mem[m_addr[9:2]] = m_wdata;
        if (m_wait >= MAX_WAIT && dma_req) g = 2;
        else if (cpu_req)                  g = 1;
        else if (dma_req)                  g = 2;
        else                               g = 0;
        if (dma_req && g != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else                   m_wait = 0;
        if (g == 1) begin
            m_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wdata;
        end else if (g == 2) begin
            m_wr = dma_wr; m_addr = dma_addr; m_wdata = dma_wdata;
        end
        m_owner = g;
        if (g != 0 && !m_wr) exp_q.push_back(ref_mem[m_addr[9:2]]);
    endtask

    function automatic obs_t exp_out();
        obs_t e;
        e = '0;
        if (m_owner == 1) begin
            e.cpu_ack   = 1'b1;
            e.dm_we     = m_wr;
            e.dm_addr   = m_addr;
            e.dm_wdata  = m_wdata;
            e.cpu_rdata = ref_mem[m_addr[9:2]];
        end else if (m_owner == 2) begin
            e.dma_ack   = 1'b1;
            e.dma_err   = blocked();
            e.dm_we     = m_wr && !blocked();
            e.dm_addr   = m_addr;
            e.dm_wdata  = m_wdata;
            e.dma_rdata = ref_mem[m_addr[9:2]];
        end
        e.cpu_stall = cpu_req && !e.cpu_ack;
        return e;
    endfunction

    function automatic obs_t act_out();
        obs_t a;
        a = {cpu_ack, dma_ack, dma_err, dm_we, cpu_stall, dm_addr, dm_wdata, cpu_rdata, dma_rdata};
        return a;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        model_clock();
        tick();
    endtask

    task automatic cpu_drive(input logic req, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
        cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic dma_drive(input logic req, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
        dma_req = req; dma_wr = wr; dma_addr = addr; dma_wdata = wdata;
    endtask

    // tests
    task automatic test_reset();
        obs_t a, e;
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            dma_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            tick();
            model_reset();
            a = act_out(); e = exp_out();
            total++;
            if (a !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", a, e); end
            total++;
            if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        end
        rstn = 1'b1;
        cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
        dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || cpu_ack !== 1'b1) begin bad++; $display("FAIL reset_first_ack got=%h want=%h", a, e); end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e) begin bad++; $display("FAIL reset_back_idle got=%h want=%h", a, e); end
    endtask

    task automatic test_cpu_store_load();
        obs_t a, e;
        cpu_drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        total++;
        if (cpu_stall !== 1'b1) begin bad++; $display("FAIL cpu_stall_wait got=%b want=1", cpu_stall); end
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || dm_we !== 1'b1 || dm_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL cpu_store got=%h want=%h", a, e);
        end
        cpu_drive(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || cpu_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL cpu_load got=%h want=%h rdata=%h", a, e, cpu_rdata);
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_contention();
        obs_t a, e;
        int first_dma, cpu_before, cpu_after;
        first_dma = -1; cpu_before = 0; cpu_after = 0;
        cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
        dma_drive(1'b1, 1'b0, 32'h84, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            step();
            a = act_out(); e = exp_out();
            total++;
            if (a !== e) begin bad++; $display("FAIL contention_cycle%0d got=%h want=%h", c, a, e); end
            total++;
            if (cpu_ack && dma_ack) begin bad++; $display("FAIL ack_overlap cycle=%0d got=11 want=not both", c); end
            if (cpu_ack && first_dma < 0) cpu_before++;
            if (cpu_ack && first_dma > 0) cpu_after++;
            if (dma_ack && first_dma < 0) begin
                first_dma = c;
                dma_req = 1'b0;
            end
        end
        total++;
        if (first_dma != MAX_WAIT + 1 || cpu_before != MAX_WAIT) begin
            bad++; $display("FAIL starvation_guard got dma_at=%0d cpu_before=%0d want dma_at=%0d cpu_before=%0d",
                            first_dma, cpu_before, MAX_WAIT + 1, MAX_WAIT);
        end
        total++;
        if (cpu_after != 8 - (MAX_WAIT + 1)) begin
            bad++; $display("FAIL cpu_resume got=%0d want=%0d", cpu_after, 8 - (MAX_WAIT + 1));
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_dma_only();
        obs_t a, e;
        logic [31:0] want;
        want = PROT ? 32'h0 : 32'h12345678;
        dma_drive(1'b1, 1'b1, 32'h20, 32'h12345678);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || dma_ack !== 1'b1 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL dma_write got=%h want=%h", a, e);
        end
        dma_drive(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || dma_rdata !== want || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL dma_read got=%h want=%h rdata=%h", a, e, dma_rdata);
        end
        dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid_access();
        obs_t a, e;
        cpu_drive(1'b1, 1'b1, 32'h30, 32'h55);
        step();
        total++;
        if (dm_we !== 1'b1) begin bad++; $display("FAIL mid_reset_we_before got=%b want=1", dm_we); end
        rstn = 1'b0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        #1;
        total++;
        if (dm_we !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL mid_reset_abort got we=%b ack=%b want we=0 ack=0", dm_we, cpu_ack);
        end
        tick();
        rstn = 1'b1;
        cpu_drive(1'b1, 1'b0, 32'h30, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || cpu_rdata === 32'h55) begin
            bad++; $display("FAIL mid_reset_readback got=%h want=%h", a, e);
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_protection();
        obs_t a, e;
        dma_drive(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || dma_ack !== 1'b1 || dma_err !== PROT || dm_we !== !PROT) begin
            bad++; $display("FAIL prot_inside got=%h want=%h", a, e);
        end
        dma_drive(1'b1, 1'b1, 32'h100, 32'h0BADF00D);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e || dma_err !== 1'b0 || dm_we !== 1'b1) begin
            bad++; $display("FAIL prot_outside got=%h want=%h", a, e);
        end
        dma_drive(1'b1, 1'b0, 32'h40, 32'h0);
        step();
        total++;
        if (dma_rdata !== (PROT ? 32'h0 : 32'hA5A5A5A5)) begin
            bad++; $display("FAIL prot_read_inside got=%h want=%h", dma_rdata, PROT ? 32'h0 : 32'hA5A5A5A5);
        end
        dma_drive(1'b1, 1'b0, 32'h100, 32'h0);
        step();
        total++;
        if (dma_rdata !== 32'h0BADF00D) begin
            bad++; $display("FAIL prot_read_outside got=%h want=0badf00d", dma_rdata);
        end
        dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_random();
        obs_t a, e;
        logic [31:0] want;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            if (!(cpu_req && !cpu_ack))
                cpu_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            if (!(dma_req && !dma_ack))
                dma_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            step();
            a = act_out(); e = exp_out();
            total++;
            if (a !== e) begin bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, a, e); end
            if (m_owner != 0 && !m_wr) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL random_read%0d got=empty want=queued", i);
                end else begin
                    want = exp_q.pop_front();
                    if ((cpu_ack ? cpu_rdata : dma_rdata) !== want) begin
                        bad++; $display("FAIL random_read%0d got=%h want=%h", i,
                                        cpu_ack ? cpu_rdata : dma_rdata, want);
                    end
                end
            end
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        a = act_out(); e = exp_out();
        total++;
        if (a !== e) begin bad++; $display("FAIL random_drain got=%h want=%h", a, e); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
        model_reset();
        test_reset();
        test_cpu_store_load();
        test_contention();
        test_dma_only();
        test_reset_mid_access();
        test_protection();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
